// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and size helper for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP,
    LSU_ERR
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Byte mask of an access whose size is 2**sz bytes.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side request/response bundle and data-memory bundle of the LSU.
// Signal suffixes give direction as seen from the LSU.
interface lsu_req_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [2:0]            req_funct3_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [XLEN-1:0]       req_wdata_i;
  logic [4:0]            req_rd_i;
  logic                  resp_valid_o;
  logic [XLEN-1:0]       resp_rdata_o;
  logic [4:0]            resp_rd_o;
  logic                  resp_err_o;
  logic                  busy_o;

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_rd_o, resp_err_o, busy_o
  );
  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_rd_o, resp_err_o, busy_o
  );
endinterface

interface lsu_dm_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  dm_req_o;
  logic                  dm_we_o;
  logic [XLEN/8-1:0]     dm_be_o;
  logic [ADDR_WIDTH-1:0] dm_addr_o;
  logic [XLEN-1:0]       dm_din_o;
  logic [XLEN-1:0]       dm_dout_i;
  logic                  dm_ack_i;

  modport master (
    output dm_req_o, dm_we_o, dm_be_o, dm_addr_o, dm_din_o,
    input  dm_dout_i, dm_ack_i
  );
  modport slave (
    input  dm_req_o, dm_we_o, dm_be_o, dm_addr_o, dm_din_o,
    output dm_dout_i, dm_ack_i
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational access checking, store lane shifting and load extraction.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int BEW  = XLEN / 8,
  localparam int OFFW = $clog2(BEW)
) (
  input  logic            we_i,
  input  logic [2:0]      funct3_i,
  input  logic [OFFW-1:0] off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [2:0]      ld_funct3_i,
  input  logic [OFFW-1:0] ld_off_i,
  input  logic [XLEN-1:0] ld_dout_i,
  output logic            bad_o,
  output logic [BEW-1:0]  be_o,
  output logic [XLEN-1:0] din_o,
  output logic [XLEN-1:0] rdata_o
);

  logic            legal;
  logic            misal;
  logic [2:0]      off3;
  logic [XLEN-1:0] sh;

  always_comb begin
    legal = 1'b0;
    case (funct3_i)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_D:             legal = (XLEN == 64);
      F3_BU, F3_HU:     legal = !we_i;
      F3_WU:            legal = !we_i && (XLEN == 64);
      default:          legal = 1'b0;
    endcase
  end

  // Low offset bits must be clear up to the access size.
  assign off3  = 3'(off_i);
  assign misal = |(off3 & 3'((4'd1 << funct3_i[1:0]) - 4'd1));
  assign bad_o = !legal || misal;

  assign be_o  = BEW'(size_mask(funct3_i[1:0]) << off_i);
  assign din_o = wdata_i << {off_i, 3'b000};

  assign sh = ld_dout_i >> {ld_off_i, 3'b000};

  always_comb begin
    rdata_o = '0;
    case (ld_funct3_i)
      F3_B:    rdata_o = XLEN'($signed(sh[7:0]));
      F3_H:    rdata_o = XLEN'($signed(sh[15:0]));
      F3_W:    rdata_o = XLEN'($signed(sh[31:0]));
      F3_BU:   rdata_o = XLEN'(sh[7:0]);
      F3_HU:   rdata_o = XLEN'(sh[15:0]);
      F3_WU:   rdata_o = XLEN'(sh[31:0]);
      default: rdata_o = sh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one access in IDLE, drives data memory until ack
// or timeout, then returns a single-cycle response.
//   state    | meaning
//   LSU_IDLE | ready for a request
//   LSU_REQ  | dm_req_o held, waiting for ack or timeout
//   LSU_RESP | response pulse for a completed access
//   LSU_ERR  | error response pulse (bad access or timeout)
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic      clk_i,
  input logic      rst_n_i,
  lsu_req_if.slave req,
  lsu_dm_if.master dm
);

  localparam int BEW  = XLEN / 8;
  localparam int OFFW = $clog2(BEW);
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t            state_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [XLEN-1:0]       resp_rdata_q;
  logic [4:0]            resp_rd_q;
  logic                  dm_req_q;
  logic                  dm_we_q;
  logic [BEW-1:0]        dm_be_q;
  logic [ADDR_WIDTH-1:0] dm_addr_q;
  logic [XLEN-1:0]       dm_din_q;
  logic [2:0]            ld_funct3_q;
  logic [OFFW-1:0]       ld_off_q;
  logic [CNTW-1:0]       cnt_q;

  logic                  bad;
  logic [BEW-1:0]        be;
  logic [XLEN-1:0]       din;
  logic [XLEN-1:0]       ld_data;

  lsu_align #(.XLEN(XLEN)) u_align (
    .we_i        (req.req_we_i),
    .funct3_i    (req.req_funct3_i),
    .off_i       (req.req_addr_i[OFFW-1:0]),
    .wdata_i     (req.req_wdata_i),
    .ld_funct3_i (ld_funct3_q),
    .ld_off_i    (ld_off_q),
    .ld_dout_i   (dm.dm_dout_i),
    .bad_o       (bad),
    .be_o        (be),
    .din_o       (din),
    .rdata_o     (ld_data)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= LSU_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_be_q      <= '0;
      dm_addr_q    <= '0;
      dm_din_q     <= '0;
      ld_funct3_q  <= '0;
      ld_off_q     <= '0;
      cnt_q        <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (req.req_valid_i) begin
            req_ready_q  <= 1'b0;
            resp_rd_q    <= req.req_rd_i;
            resp_rdata_q <= '0;
            ld_funct3_q  <= req.req_funct3_i;
            ld_off_q     <= req.req_addr_i[OFFW-1:0];
            if (bad) begin
              state_q      <= LSU_ERR;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q   <= LSU_REQ;
              dm_req_q  <= 1'b1;
              dm_we_q   <= req.req_we_i;
              dm_be_q   <= be;
              dm_addr_q <= {req.req_addr_i[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
              dm_din_q  <= req.req_we_i ? din : '0;
              cnt_q     <= CNTW'(TIMEOUT_CYCLES - 1);
            end
          end
        end
        LSU_REQ: begin
          if (dm.dm_ack_i) begin
            state_q      <= LSU_RESP;
            dm_req_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= dm_we_q ? '0 : ld_data;
          end else if (cnt_q == '0) begin
            state_q      <= LSU_ERR;
            dm_req_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q     <= LSU_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req.req_ready_o  = req_ready_q;
  assign req.resp_valid_o = resp_valid_q;
  assign req.resp_err_o   = resp_err_q;
  assign req.resp_rdata_o = resp_rdata_q;
  assign req.resp_rd_o    = resp_rd_q;
  assign req.busy_o       = (state_q != LSU_IDLE);

  assign dm.dm_req_o  = dm_req_q;
  assign dm.dm_we_o   = dm_we_q;
  assign dm.dm_be_o   = dm_be_q;
  assign dm.dm_addr_o = dm_addr_q;
  assign dm.dm_din_o  = dm_din_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a 32-bit instance (timeout 4) and a 64-bit one (timeout 6).
module tb_lsu;
  import lsu_pkg::*;

  typedef struct {
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        err;
    longint      t_resp;
  } exp_t;

  typedef struct {
    int          delay;
    bit          noack;
    logic [63:0] dout;
    logic        we;
    logic [7:0]  be;
    logic [31:0] addr;
    logic [63:0] din;
    longint      t_req;
  } mem_t;

  logic   clk = 1'b0;
  logic   rst_n [2];
  longint cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  int     xl  [2] = '{32, 64};
  int     tmo [2] = '{4, 6};

  exp_t eq0[$], eq1[$];
  mem_t mq0[$], mq1[$];

  logic        valid [2], we_b [2], ack_b [2];
  logic [2:0]  f3_b [2];
  logic [31:0] addr_b [2];
  logic [63:0] wdata_b [2], dout_b [2];
  logic [4:0]  rd_b [2];

  logic        ready [2], rv [2], rerr [2], busy [2], dmreq [2], dmwe [2];
  logic [63:0] rdata [2], din [2];
  logic [7:0]  be [2];
  logic [31:0] dmaddr [2];
  logic [4:0]  rrd [2];

  lsu_req_if #(.XLEN(32), .ADDR_WIDTH(32)) r32 ();
  lsu_dm_if  #(.XLEN(32), .ADDR_WIDTH(32)) m32 ();
  lsu_req_if #(.XLEN(64), .ADDR_WIDTH(32)) r64 ();
  lsu_dm_if  #(.XLEN(64), .ADDR_WIDTH(32)) m64 ();

  lsu #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n[0]), .req(r32), .dm(m32));
  lsu #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(6)) dut64 (
    .clk_i(clk), .rst_n_i(rst_n[1]), .req(r64), .dm(m64));

  assign r32.req_valid_i  = valid[0];
  assign r32.req_we_i     = we_b[0];
  assign r32.req_funct3_i = f3_b[0];
  assign r32.req_addr_i   = addr_b[0];
  assign r32.req_wdata_i  = wdata_b[0][31:0];
  assign r32.req_rd_i     = rd_b[0];
  assign m32.dm_dout_i    = dout_b[0][31:0];
  assign m32.dm_ack_i     = ack_b[0];
  assign ready[0]  = r32.req_ready_o;
  assign rv[0]     = r32.resp_valid_o;
  assign rerr[0]   = r32.resp_err_o;
  assign rdata[0]  = {32'h0, r32.resp_rdata_o};
  assign rrd[0]    = r32.resp_rd_o;
  assign busy[0]   = r32.busy_o;
  assign dmreq[0]  = m32.dm_req_o;
  assign dmwe[0]   = m32.dm_we_o;
  assign be[0]     = {4'h0, m32.dm_be_o};
  assign dmaddr[0] = m32.dm_addr_o;
  assign din[0]    = {32'h0, m32.dm_din_o};

  assign r64.req_valid_i  = valid[1];
  assign r64.req_we_i     = we_b[1];
  assign r64.req_funct3_i = f3_b[1];
  assign r64.req_addr_i   = addr_b[1];
  assign r64.req_wdata_i  = wdata_b[1];
  assign r64.req_rd_i     = rd_b[1];
  assign m64.dm_dout_i    = dout_b[1];
  assign m64.dm_ack_i     = ack_b[1];
  assign ready[1]  = r64.req_ready_o;
  assign rv[1]     = r64.resp_valid_o;
  assign rerr[1]   = r64.resp_err_o;
  assign rdata[1]  = r64.resp_rdata_o;
  assign rrd[1]    = r64.resp_rd_o;
  assign busy[1]   = r64.busy_o;
  assign dmreq[1]  = m64.dm_req_o;
  assign dmwe[1]   = m64.dm_we_o;
  assign be[1]     = m64.dm_be_o;
  assign dmaddr[1] = m64.dm_addr_o;
  assign din[1]    = m64.dm_din_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int s, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (dut%0d) at cycle %0d: got %h expected %h", name, xl[s], cyc, act, exp);
    end
  endfunction

  // Reference behaviour from the access rules: size/sign/legality per funct3,
  // byte lanes picked out of the memory word one by one.
  function automatic void ref_model(input int xlen, input bit w, input logic [2:0] f3,
      input logic [31:0] a, input logic [63:0] wd, input logic [63:0] dout,
      output bit err, output logic [7:0] ebe, output logic [63:0] edin,
      output logic [63:0] erd, output logic [31:0] ea);
    int nb, size, off;
    bit sgn, legal;
    logic [63:0] xmask, val;
    nb    = xlen / 8;
    xmask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    sgn = 1'b0; size = 1; legal = 1'b0;
    case (f3)
      3'b000: begin size = 1; sgn = 1'b1; legal = 1'b1; end
      3'b001: begin size = 2; sgn = 1'b1; legal = 1'b1; end
      3'b010: begin size = 4; sgn = (xlen == 64); legal = 1'b1; end
      3'b011: begin size = 8; legal = (xlen == 64); end
      3'b100: begin size = 1; legal = !w; end
      3'b101: begin size = 2; legal = !w; end
      3'b110: begin size = 4; legal = !w && (xlen == 64); end
      default: legal = 1'b0;
    endcase
    off  = int'(a % 32'(nb));
    err  = !legal || ((off % size) != 0);
    ea   = a - 32'(off);
    ebe  = '0;
    val  = '0;
    for (int i = 0; i < size; i++) begin
      if (off + i < 8) begin
        ebe[off + i]   = 1'b1;
        val[8*i +: 8]  = dout[8*(off + i) +: 8];
      end
    end
    if (sgn && val[8*size - 1])
      for (int j = 8*size; j < 64; j++) val[j] = 1'b1;
    edin = (wd << (8*off)) & xmask;
    erd  = (w || err) ? 64'h0 : (val & xmask);
  endfunction

  task automatic issue(input int s, input bit w, input logic [2:0] f3, input logic [31:0] a,
      input logic [63:0] wd, input logic [4:0] rd, input int dly, input bit na,
      input logic [63:0] dout, input bit kill);
    bit err;
    logic [7:0] ebe;
    logic [63:0] edin, erd;
    logic [31:0] ea;
    longint t;
    int n;
    exp_t e;
    mem_t m;
    n = 0;
    @(negedge clk);
    while (!ready[s] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ready_timeout", s, 64'(ready[s]), 64'h1);
    valid[s] = 1'b1; we_b[s] = w; f3_b[s] = f3; addr_b[s] = a; wdata_b[s] = wd; rd_b[s] = rd;
    @(posedge clk);
    #1;
    t = cyc;
    valid[s] = 1'b0;
    ref_model(xl[s], w, f3, a, wd, dout, err, ebe, edin, erd, ea);
    if (!err) begin
      m = '{delay: dly, noack: na, dout: dout, we: w, be: ebe, addr: ea, din: edin, t_req: t};
      if (s == 0) mq0.push_back(m); else mq1.push_back(m);
    end
    if (kill) begin
      @(negedge clk); @(negedge clk);
      rst_n[s] = 1'b0;
      #1;
      chk("kill_dm_req", s, 64'(dmreq[s]), 64'h0);
      chk("kill_busy", s, 64'(busy[s]), 64'h0);
      chk("kill_ready", s, 64'(ready[s]), 64'h1);
      chk("kill_resp_valid", s, 64'(rv[s]), 64'h0);
      @(negedge clk);
      rst_n[s] = 1'b1;
      repeat (4) @(negedge clk);
      return;
    end
    if (err)     e = '{rdata: 64'h0, rd: rd, err: 1'b1, t_resp: t};
    else if (na) e = '{rdata: 64'h0, rd: rd, err: 1'b1, t_resp: t + longint'(tmo[s])};
    else         e = '{rdata: erd,   rd: rd, err: 1'b0, t_resp: t + longint'(dly) + 1};
    if (s == 0) eq0.push_back(e); else eq1.push_back(e);
    // Garbage on req_* while busy must not disturb the access in flight.
    n = 0;
    forever begin
      @(negedge clk);
      if (rv[s] || !busy[s] || n > 40) begin valid[s] = 1'b0; break; end
      valid[s] = 1'b1; we_b[s] = 1'($urandom); f3_b[s] = 3'($urandom);
      addr_b[s] = $urandom; wdata_b[s] = {$urandom, $urandom}; rd_b[s] = 5'($urandom);
      n++;
    end
  endtask

  task automatic monitor(input int s);
    exp_t e;
    forever begin
      @(negedge clk);
      if (rv[s]) begin
        if ((s == 0 && eq0.size() == 0) || (s == 1 && eq1.size() == 0)) begin
          chk("resp_unexpected", s, 64'(rv[s]), 64'h0);
        end else begin
          e = (s == 0) ? eq0.pop_front() : eq1.pop_front();
          chk("resp_rdata", s, rdata[s], e.rdata);
          chk("resp_rd", s, 64'(rrd[s]), 64'(e.rd));
          chk("resp_err", s, 64'(rerr[s]), 64'(e.err));
          chk("resp_cycle", s, 64'(cyc), 64'(e.t_resp));
        end
      end
    end
  endtask

  task automatic responder(input int s);
    mem_t m;
    bit active;
    int w, hi;
    active = 1'b0; w = 0; hi = 0;
    m = '{delay: 0, noack: 1'b1, dout: 64'h0, we: 1'b0, be: 8'h0, addr: 32'h0, din: 64'h0, t_req: 0};
    forever begin
      @(negedge clk);
      dout_b[s] = {$urandom, $urandom};
      if (!rst_n[s]) begin
        active = 1'b0; ack_b[s] = 1'b0;
      end else if (dmreq[s]) begin
        if (!active) begin
          active = 1'b1; w = 0; hi = 0;
          if ((s == 0 && mq0.size() == 0) || (s == 1 && mq1.size() == 0)) begin
            chk("dm_unexpected", s, 64'(dmreq[s]), 64'h0);
            m.noack = 1'b1; m.t_req = -1;
          end else begin
            m = (s == 0) ? mq0.pop_front() : mq1.pop_front();
            chk("dm_start_cycle", s, 64'(cyc), 64'(m.t_req));
          end
        end
        if (m.t_req >= 0) begin
          chk("dm_we", s, 64'(dmwe[s]), 64'(m.we));
          chk("dm_addr", s, 64'(dmaddr[s]), 64'(m.addr));
          if (m.we) begin
            chk("dm_be", s, 64'(be[s]), 64'(m.be));
            chk("dm_din", s, din[s], m.din);
          end
        end
        hi++;
        if (!m.noack && w == m.delay) begin
          ack_b[s] = 1'b1; dout_b[s] = m.dout;
        end else begin
          ack_b[s] = 1'b0; w++;
        end
      end else begin
        if (active && m.noack && m.t_req >= 0) chk("dm_hold_cycles", s, 64'(hi), 64'(tmo[s]));
        active = 1'b0;
        ack_b[s] = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  task automatic rand_run(input int s, input int count);
    logic [31:0] a;
    for (int i = 0; i < count; i++) begin
      a = $urandom & 32'hFFFF_FFF8;
      if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(0, 7));
      issue(s, 1'($urandom), 3'($urandom), a, {$urandom, $urandom}, 5'($urandom),
            $urandom_range(0, 3), ($urandom_range(0, 9) == 0), {$urandom, $urandom}, 1'b0);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; valid[s] = 1'b0; we_b[s] = 1'b0; f3_b[s] = 3'b0; addr_b[s] = 32'h0;
      wdata_b[s] = 64'h0; rd_b[s] = 5'h0; ack_b[s] = 1'b0; dout_b[s] = 64'h0;
    end
    fork
      monitor(0); monitor(1); responder(0); responder(1);
    join_none

    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", s, 64'(ready[s]), 64'h1);
      chk("rst_resp_valid", s, 64'(rv[s]), 64'h0);
      chk("rst_resp_err", s, 64'(rerr[s]), 64'h0);
      chk("rst_busy", s, 64'(busy[s]), 64'h0);
      chk("rst_dm_req", s, 64'(dmreq[s]), 64'h0);
      chk("rst_rdata", s, rdata[s], 64'h0);
      chk("rst_be", s, 64'(be[s]), 64'h0);
      chk("rst_dm_addr", s, 64'(dmaddr[s]), 64'h0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);

    issue(0, 1'b1, F3_W,  32'h104, 64'hDEADBEEF, 5'd1, 1, 1'b0, 64'h0, 1'b0);
    issue(0, 1'b1, F3_B,  32'h103, 64'h5A,       5'd2, 0, 1'b0, 64'h0, 1'b0);
    issue(0, 1'b0, F3_B,  32'h103, 64'h0,        5'd3, 0, 1'b0, 64'h80123456, 1'b0);
    issue(0, 1'b0, F3_HU, 32'h102, 64'h0,        5'd4, 2, 1'b0, 64'h80011234, 1'b0);
    issue(0, 1'b0, F3_H,  32'h102, 64'h0,        5'd7, 0, 1'b0, 64'h80011234, 1'b0);
    issue(0, 1'b0, F3_W,  32'h101, 64'h0,        5'd8, 0, 1'b0, 64'h0, 1'b0);
    issue(0, 1'b0, F3_D,  32'h100, 64'h0,        5'd9, 0, 1'b0, 64'h0, 1'b0);
    issue(0, 1'b0, F3_W,  32'h200, 64'h0,        5'd10, 0, 1'b1, 64'h0, 1'b0);
    issue(0, 1'b1, F3_H,  32'h20E, 64'hCAFE1234, 5'd11, 3, 1'b0, 64'h0, 1'b0);

    issue(1, 1'b0, F3_WU, 32'h1004, 64'h0, 5'd12, 1, 1'b0, 64'hF0000000_12345678, 1'b0);
    issue(1, 1'b0, F3_W,  32'h100C, 64'h0, 5'd13, 0, 1'b0, 64'h80000001_00000000, 1'b0);
    issue(1, 1'b0, F3_D,  32'h1108, 64'h0, 5'd14, 2, 1'b0, 64'h89ABCDEF_01234567, 1'b0);
    issue(1, 1'b1, F3_D,  32'h1110, 64'h11223344_55667788, 5'd15, 0, 1'b0, 64'h0, 1'b0);
    issue(1, 1'b1, F3_W,  32'h1114, 64'hA5A5A5A5, 5'd16, 1, 1'b0, 64'h0, 1'b0);
    issue(1, 1'b1, F3_WU, 32'h1118, 64'h0, 5'd17, 0, 1'b0, 64'h0, 1'b0);
    issue(1, 1'b0, F3_D,  32'h1104, 64'h0, 5'd18, 0, 1'b0, 64'h0, 1'b0);
    issue(1, 1'b0, F3_D,  32'h1200, 64'h0, 5'd19, 0, 1'b1, 64'h0, 1'b0);
    issue(1, 1'b0, F3_D,  32'h1120, 64'h0, 5'd20, 0, 1'b1, 64'h0, 1'b1);
    issue(1, 1'b0, F3_HU, 32'h1126, 64'h0, 5'd21, 0, 1'b0, 64'hBEEF0000_00000000, 1'b0);

    rand_run(0, 40);
    rand_run(1, 40);

    begin
      int n;
      n = 0;
      while ((eq0.size() != 0 || eq1.size() != 0) && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("drain_timeout", 0, 64'(eq0.size() + eq1.size()), 64'h0);
    end
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
